// File: rtl/junction_ctrl.sv
// junction_ctrl
// Round-robin junction controller: NUM_PH vehicle approaches share the
// green one at a time, and every crosswalk request is served together in an
// all-way pedestrian scramble (all vehicle heads red) between greens.
//
// Build option: define PED_FLASH_EN to include the flashing-don't-walk
// (FLASH) interval after WALK. Without it WALK returns straight to GREEN,
// ped_flash is tied low and T_FLASH is not used.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active high
//   btn        crosswalk buttons (synchronised, debounced, level-sensitive)
//   veh_grn    green lamp per approach
//   veh_yel    yellow lamp per approach
//   veh_red    red lamp per approach
//   ped_walk   walk lamp per crosswalk
//   ped_flash  common flashing-don't-walk indication
//   req_pend   latched crosswalk requests not yet served
//   phase      approach that currently owns (or last owned) the green
module junction_ctrl #(
    parameter int TP          = 1,
    parameter int NUM_PH      = 2,
    parameter int TW          = 6,
    parameter int CLK_DIV     = 1,
    parameter int T_MIN_GREEN = 10,
    parameter int T_MAX_GREEN = 59,
    parameter int T_YELLOW    = 4,
    parameter int T_ALL_RED   = 1,
    parameter int T_WALK      = 29,
    parameter int T_FLASH     = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_PH-1:0]         btn,
    output logic [NUM_PH-1:0]         veh_grn,
    output logic [NUM_PH-1:0]         veh_yel,
    output logic [NUM_PH-1:0]         veh_red,
    output logic [NUM_PH-1:0]         ped_walk,
    output logic                      ped_flash,
    output logic [NUM_PH-1:0]         req_pend,
    output logic [$clog2(NUM_PH)-1:0] phase
);

    localparam int PHW = $clog2(NUM_PH);
    localparam int PSW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // Last timer value of each interval; the state changes on that tick.
    localparam logic [TW-1:0] MIN_END = TW'(T_MIN_GREEN - 1);
    localparam logic [TW-1:0] MAX_END = TW'(T_MAX_GREEN - 1);
    localparam logic [TW-1:0] YEL_END = TW'(T_YELLOW - 1);
    localparam logic [TW-1:0] AR_END  = TW'(T_ALL_RED - 1);
    localparam logic [TW-1:0] WLK_END = TW'(T_WALK - 1);

    // Parameter legality: these ranges are assumed by the timing logic;
    // nothing is generated for either outcome.
    generate
        if (NUM_PH < 2 || NUM_PH > 8 || CLK_DIV < 1 || TP < 0 ||
            T_MAX_GREEN < T_MIN_GREEN || T_MIN_GREEN < 1 ||
            T_YELLOW < 1 || T_ALL_RED < 1 || T_WALK < 1 || T_FLASH < 1 ||
            T_MAX_GREEN >= (1 << TW) || T_WALK >= (1 << TW) ||
            T_FLASH >= (1 << TW)) begin : g_cfg_illegal
        end
    endgenerate

    typedef enum logic [2:0] {
        GREEN   = 3'd0,
        YELLOW  = 3'd1,
        ALL_RED = 3'd2,
        WALK    = 3'd3
`ifdef PED_FLASH_EN
        ,
        FLASH   = 3'd4
`endif
    } state_t;

    state_t            state_reg, state_next;
    logic [PHW-1:0]    phase_reg, phase_next, phase_inc;
    logic [TW-1:0]     timer_reg, timer_next;
    logic [PSW-1:0]    pre_reg, pre_next;
    logic [NUM_PH-1:0] req_pend_reg, req_pend_next;
    logic [NUM_PH-1:0] served_reg, served_next;
    logic              tick;
    logic              snap;
    logic              state_change;

    assign tick      = (pre_reg == PSW'(CLK_DIV - 1));
    assign phase_inc = (phase_reg == PHW'(NUM_PH - 1)) ? '0 : phase_reg + PHW'(1);

    always_comb begin
        state_next  = state_reg;
        phase_next  = phase_reg;
        served_next = served_reg;
        snap        = 1'b0;
        unique case (state_reg)
            GREEN: begin
                // Leave at max green, or as soon as min green has elapsed
                // while a crosswalk request is waiting.
                if (tick && (timer_reg == MAX_END ||
                             (timer_reg >= MIN_END && |req_pend_reg)))
                    state_next = YELLOW;
            end
            YELLOW: begin
                if (tick && timer_reg == YEL_END)
                    state_next = ALL_RED;
            end
            ALL_RED: begin
                if (tick && timer_reg == AR_END) begin
                    if (|req_pend_reg) begin
                        state_next  = WALK;
                        served_next = req_pend_reg;
                        snap        = 1'b1;
                    end else begin
                        state_next = GREEN;
                        phase_next = phase_inc;
                    end
                end
            end
            WALK: begin
                if (tick && timer_reg == WLK_END) begin
`ifdef PED_FLASH_EN
                    state_next = FLASH;
`else
                    state_next = GREEN;
                    phase_next = phase_inc;
`endif
                end
            end
`ifdef PED_FLASH_EN
            FLASH: begin
                if (tick && timer_reg == TW'(T_FLASH - 1)) begin
                    state_next = GREEN;
                    phase_next = phase_inc;
                end
            end
`endif
            default: state_next = ALL_RED;
        endcase
    end

    // Every transition goes to a different state, so a change of state
    // marks the start of a fresh interval.
    assign state_change = (state_next != state_reg);
    assign timer_next   = state_change ? '0 : (tick ? timer_reg + TW'(1) : timer_reg);
    assign pre_next     = (state_change || tick) ? '0 : pre_reg + PSW'(1);

    // Presses are blocked on crosswalks that are walking; the snapshot clear
    // overrides a press on the same bit in the same cycle.
    assign req_pend_next = (req_pend_reg | (btn & ~ped_walk)) &
                           ~(snap ? req_pend_reg : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ALL_RED;
            phase_reg    <= PHW'(NUM_PH - 1);
            timer_reg    <= '0;
            pre_reg      <= '0;
            req_pend_reg <= '0;
            served_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            phase_reg    <= phase_next;
            timer_reg    <= timer_next;
            pre_reg      <= pre_next;
            req_pend_reg <= req_pend_next;
            served_reg   <= served_next;
        end
    end

    // Lamp decode: red is the complement of green/yellow so that exactly one
    // vehicle lamp is lit per approach.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PH; gi++) begin : g_lamp
            logic own;
            assign own          = (phase_reg == PHW'(gi));
            assign veh_grn[gi]  = (state_reg == GREEN) && own;
            assign veh_yel[gi]  = (state_reg == YELLOW) && own;
            assign veh_red[gi]  = !((state_reg == GREEN || state_reg == YELLOW) && own);
            assign ped_walk[gi] = (state_reg == WALK) && served_reg[gi];
        end
    endgenerate

`ifdef PED_FLASH_EN
    assign ped_flash = (state_reg == FLASH);
`else
    assign ped_flash = 1'b0;
`endif

    assign req_pend = req_pend_reg;
    assign phase    = phase_reg;

endmodule

// File: tb/tb_junction_ctrl.sv
// Testbench for junction_ctrl. Two instances: dut_a (CLK_DIV=1) exercises
// the request/walk/reset sequences, dut_b (CLK_DIV=4) the prescaled timing.
// Expected output vectors are queued per cycle; a monitor pops and compares
// them on the falling edge.
module tb_junction_ctrl;

    typedef struct {
        int          cyc;
        string       name;
        logic [11:0] v;   // {grn, yel, red, walk, flash, req, phase}
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1, rst_b = 1'b1;
    logic [1:0] btn_a = 2'b00, btn_b = 2'b00;
    logic [1:0] grn_a, yel_a, red_a, walk_a, req_a;
    logic [1:0] grn_b, yel_b, red_b, walk_b, req_b;
    logic       flash_a, flash_b;
    logic [0:0] phase_a, phase_b;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_a[$];
    exp_t sb_b[$];

    junction_ctrl #(.NUM_PH(2), .CLK_DIV(1)) dut_a (
        .clk(clk), .rst(rst_a), .btn(btn_a),
        .veh_grn(grn_a), .veh_yel(yel_a), .veh_red(red_a),
        .ped_walk(walk_a), .ped_flash(flash_a),
        .req_pend(req_a), .phase(phase_a)
    );

    junction_ctrl #(.NUM_PH(2), .CLK_DIV(4)) dut_b (
        .clk(clk), .rst(rst_b), .btn(btn_b),
        .veh_grn(grn_b), .veh_yel(yel_b), .veh_red(red_b),
        .ped_walk(walk_b), .ped_flash(flash_b),
        .req_pend(req_b), .phase(phase_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic seg(input int d, input int c0, input int n, input string nm,
                       input logic [1:0] g, input logic [1:0] y,
                       input logic [1:0] rd, input logic [1:0] w,
                       input logic f, input logic [1:0] rq, input logic ph);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.cyc  = c0 + k;
            e.name = nm;
            e.v    = {g, y, rd, w, f, rq, ph};
            if (d == 0) sb_a.push_back(e);
            else        sb_b.push_back(e);
        end
    endtask

    task automatic check(input exp_t e, input logic [11:0] act, input string tag);
        checks++;
        if (e.cyc != cyc || act !== e.v) begin
            errors++;
            $display("FAIL %s_%s cyc=%0d due=%0d got=%b want=%b (grn yel red walk flash req phase)",
                     tag, e.name, cyc, e.cyc, act, e.v);
        end else begin
            $display("ok   %s_%s cyc=%0d out=%b", tag, e.name, cyc, act);
        end
    endtask

    // Monitor: compares every queued expectation due at or before this cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        while (sb_a.size() > 0 && sb_a[0].cyc <= cyc) begin
            e = sb_a.pop_front();
            check(e, {grn_a, yel_a, red_a, walk_a, flash_a, req_a, phase_a}, "A");
        end
        while (sb_b.size() > 0 && sb_b[0].cyc <= cyc) begin
            e = sb_b.pop_front();
            check(e, {grn_b, yel_b, red_b, walk_b, flash_b, req_b, phase_b}, "B");
        end
    end

    // All stimulus changes land 2 time units after a rising edge.
    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog cyc=%0d limit reached", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int r1, r, g, n;
        wait_to(3);
        rst_a = 1'b0;
        rst_b = 1'b0;
        r1 = cyc;

        // Scenario 1: no buttons, CLK_DIV=1.
        seg(0, r1,      1,  "s1_rst",     2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 2'b00, 1'b1);
        seg(0, r1 + 1,  59, "s1_green0",  2'b01, 2'b00, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0);
        seg(0, r1 + 60, 4,  "s1_yel0",    2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0);
        seg(0, r1 + 64, 1,  "s1_allred",  2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 2'b00, 1'b0);
        seg(0, r1 + 65, 2,  "s1_green1",  2'b10, 2'b00, 2'b01, 2'b00, 1'b0, 2'b00, 1'b1);

        // Prescaled timing, CLK_DIV=4: all-red 4, green 236, yellow 16.
        seg(1, r1,       4,   "cd4_rst_allred", 2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 2'b00, 1'b1);
        seg(1, r1 + 4,   236, "cd4_green0",     2'b01, 2'b00, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0);
        seg(1, r1 + 240, 16,  "cd4_yel0",       2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0);
        seg(1, r1 + 256, 4,   "cd4_allred",     2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 2'b00, 1'b0);
        seg(1, r1 + 260, 2,   "cd4_green1",     2'b10, 2'b00, 2'b01, 2'b00, 1'b0, 2'b00, 1'b1);

        // Scenarios 2/3: request on crosswalk 1, then presses during its walk.
        wait_to(r1 + 67);
        rst_a = 1'b1;
        wait_to(r1 + 69);
        rst_a = 1'b0;
        r = cyc;
        seg(0, r,      1,  "s2_rst",        2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 2'b00, 1'b1);
        seg(0, r + 1,  3,  "s2_green0",     2'b01, 2'b00, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0);
        seg(0, r + 4,  7,  "s2_green0_req", 2'b01, 2'b00, 2'b10, 2'b00, 1'b0, 2'b10, 1'b0);
        seg(0, r + 11, 4,  "s2_yel0",       2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 2'b10, 1'b0);
        seg(0, r + 15, 1,  "s2_allred",     2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 2'b10, 1'b0);
        seg(0, r + 16, 5,  "s2_walk1",      2'b00, 2'b00, 2'b11, 2'b10, 1'b0, 2'b00, 1'b0);
        seg(0, r + 21, 24, "s3_walk1_req0", 2'b00, 2'b00, 2'b11, 2'b10, 1'b0, 2'b01, 1'b0);
`ifdef PED_FLASH_EN
        seg(0, r + 45, 5,  "s2_flash",      2'b00, 2'b00, 2'b11, 2'b00, 1'b1, 2'b01, 1'b0);
        g = r + 50;
`else
        g = r + 45;
`endif
        seg(0, g,      10, "s3_green1",     2'b10, 2'b00, 2'b01, 2'b00, 1'b0, 2'b01, 1'b1);
        seg(0, g + 10, 4,  "s3_yel1",       2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 2'b01, 1'b1);
        seg(0, g + 14, 1,  "s3_allred",     2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 2'b01, 1'b1);
        seg(0, g + 15, 29, "s3_walk0",      2'b00, 2'b00, 2'b11, 2'b01, 1'b0, 2'b00, 1'b1);
`ifdef PED_FLASH_EN
        seg(0, g + 44, 5,  "s3_flash",      2'b00, 2'b00, 2'b11, 2'b00, 1'b1, 2'b00, 1'b1);
        n = g + 49;
`else
        n = g + 44;
`endif
        seg(0, n,      2,  "s3_green0",     2'b01, 2'b00, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0);

        wait_to(r + 3);
        btn_a = 2'b10;
        wait_to(r + 4);
        btn_a = 2'b00;
        wait_to(r + 20);
        btn_a = 2'b11;
        wait_to(r + 21);
        btn_a = 2'b10;
        wait_to(r + 30);
        btn_a = 2'b00;

        // Scenario 4: reset in the middle of yellow with both requests latched.
        wait_to(n + 2);
        rst_a = 1'b1;
        wait_to(n + 4);
        rst_a = 1'b0;
        r = cyc;
        seg(0, r,      1, "s4_rst",          2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 2'b00, 1'b1);
        seg(0, r + 1,  2, "s4_green0",       2'b01, 2'b00, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0);
        seg(0, r + 3,  8, "s4_green0_req",   2'b01, 2'b00, 2'b10, 2'b00, 1'b0, 2'b11, 1'b0);
        seg(0, r + 11, 1, "s4_yel0",         2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 2'b11, 1'b0);
        seg(0, r + 12, 3, "s4_rst_midyel",   2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 2'b00, 1'b1);
        seg(0, r + 15, 2, "s4_green0_after", 2'b01, 2'b00, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0);
        wait_to(r + 2);
        btn_a = 2'b11;
        wait_to(r + 3);
        btn_a = 2'b00;
        wait_to(r + 12);
        rst_a = 1'b1;
        wait_to(r + 14);
        rst_a = 1'b0;
        wait_to(r + 18);

        wait_to(r1 + 265);
        @(negedge clk);
        #1;
        checks++;
        if (sb_a.size() + sb_b.size() != 0) begin
            errors++;
            $display("FAIL drain leftover=%0d want=0", sb_a.size() + sb_b.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
